// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the traffic-light timer blocks
package traffic_pkg;

    localparam int TIME_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } timer_state_t;

endpackage

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down-counter with zero flag; decrement saturates at zero
module down_counter
    import traffic_pkg::*;
#(
    parameter int WIDTH = TIME_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority so a start coinciding with a tick discards the tick.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - seconds down-counter that pulses expired when a started interval elapses
module interval_timer
    import traffic_pkg::*;
#(
    parameter int WIDTH = TIME_W
) (
    input  logic             clk,
    input  logic             reset_global,
    input  logic             start_timer,
    input  logic [WIDTH-1:0] time_param_output_value,
    input  logic             enable_1Hz,
    output logic             expired
);

    timer_state_t     state_q;
    timer_state_t     state_d;
    logic             expired_q;
    logic             expired_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_zero;

    down_counter #(
        .WIDTH (WIDTH)
    ) u_down_counter (
        .clk     (clk),
        .rst_n   (reset_global),
        .load_i  (cnt_load),
        .dec_i   (cnt_dec),
        .value_i (time_param_output_value),
        .count_o (cnt_value),
        .zero_o  (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        expired_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_timer) begin
                    cnt_load = 1'b1;
                    state_d  = RUNNING;
                end
            end
            RUNNING: begin
                if (start_timer) begin
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    // A zero-length interval expires without needing any tick.
                    expired_d = 1'b1;
                    state_d   = IDLE;
                end else if (enable_1Hz) begin
                    cnt_dec = 1'b1;
                    if (cnt_value == WIDTH'(1)) begin
                        expired_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_global) begin
        if (!reset_global) begin
            state_q   <= IDLE;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - directed self-checking bench for interval_timer
module tb_interval_timer;
    import traffic_pkg::*;

    logic              clk;
    logic              reset_global;
    logic              start_timer;
    logic [TIME_W-1:0] time_param_output_value;
    logic              enable_1Hz;
    logic              expired;

    int checks   = 0;
    int failures = 0;

    interval_timer #(
        .WIDTH (TIME_W)
    ) dut (
        .clk                     (clk),
        .reset_global            (reset_global),
        .start_timer             (start_timer),
        .time_param_output_value (time_param_output_value),
        .enable_1Hz              (enable_1Hz),
        .expired                 (expired)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check expired just after the rising edge.
    task automatic run(input logic s, input int v, input logic e, input int exp_expired, input string tag);
        @(negedge clk);
        start_timer             = s;
        time_param_output_value = TIME_W'(v);
        enable_1Hz              = e;
        @(posedge clk);
        #1;
        check(tag, int'(expired), exp_expired);
    endtask

    initial begin
        reset_global            = 1'b1;
        start_timer             = 1'b0;
        time_param_output_value = '0;
        enable_1Hz              = 1'b0;

        // 1 Reset with random inputs
        #5;
        reset_global = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start_timer             = 1'($urandom_range(0, 1));
            time_param_output_value = TIME_W'($urandom_range(0, 15));
            enable_1Hz              = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_expired", int'(expired), 0);
            check("rst_state", int'(dut.state_q), int'(IDLE));
        end
        @(negedge clk);
        start_timer  = 1'b0;
        enable_1Hz   = 1'b0;
        reset_global = 1'b1;
        for (int i = 0; i < 3; i++) run(1'b0, 0, 1'b1, 0, "post_rst_idle");

        // 2 Basic interval of 3 with ticks on alternate cycles
        run(1'b1, 3, 1'b0, 0, "basic_start");
        run(1'b0, 0, 1'b1, 0, "basic_t1");
        run(1'b0, 0, 1'b0, 0, "basic_gap1");
        run(1'b0, 0, 1'b1, 0, "basic_t2");
        run(1'b0, 0, 1'b0, 0, "basic_gap2");
        run(1'b0, 0, 1'b1, 1, "basic_t3");
        run(1'b0, 0, 1'b0, 0, "basic_pulse_end");
        for (int i = 0; i < 3; i++) run(1'b0, 0, 1'b1, 0, "basic_after");

        // 3 Zero and maximum intervals
        run(1'b1, 0, 1'b0, 0, "zero_start");
        run(1'b0, 0, 1'b0, 1, "zero_pulse");
        run(1'b0, 0, 1'b0, 0, "zero_end");
        run(1'b1, 15, 1'b0, 0, "max_start");
        for (int i = 1; i < 15; i++) run(1'b0, 0, 1'b1, 0, "max_early");
        run(1'b0, 0, 1'b1, 1, "max_t15");
        run(1'b0, 0, 1'b1, 0, "max_after");

        // 4 Restart from 5 to 2 after two ticks
        run(1'b1, 5, 1'b0, 0, "rst5_start");
        run(1'b0, 0, 1'b1, 0, "rst5_t1");
        run(1'b0, 0, 1'b1, 0, "rst5_t2");
        run(1'b1, 2, 1'b0, 0, "restart2");
        run(1'b0, 0, 1'b1, 0, "restart_t1");
        run(1'b0, 0, 1'b1, 1, "restart_t2");
        for (int i = 0; i < 4; i++) run(1'b0, 0, 1'b1, 0, "restart_no_orig");

        // 5 Start and tick together: the tick is not counted
        run(1'b1, 2, 1'b1, 0, "coll_start");
        run(1'b0, 0, 1'b1, 0, "coll_t1");
        run(1'b0, 0, 1'b1, 1, "coll_t2");
        run(1'b0, 0, 1'b0, 0, "coll_end");

        // Start held three cycles with ticks: reload each cycle, count after release
        for (int i = 0; i < 3; i++) run(1'b1, 3, 1'b1, 0, "hold_start");
        run(1'b0, 0, 1'b1, 0, "hold_t1");
        run(1'b0, 0, 1'b1, 0, "hold_t2");
        run(1'b0, 0, 1'b1, 1, "hold_t3");

        // Start in the cycle expired is high: pulse ends, new load proceeds
        run(1'b1, 1, 1'b0, 0, "back_start");
        run(1'b0, 0, 1'b1, 1, "back_t1");
        run(1'b1, 1, 1'b0, 0, "back_restart");
        run(1'b0, 0, 1'b1, 1, "back_t1b");

        // 6 Async reset mid-count
        run(1'b1, 4, 1'b0, 0, "ar_start");
        run(1'b0, 0, 1'b1, 0, "ar_t1");
        run(1'b0, 0, 1'b1, 0, "ar_t2");
        #10 reset_global = 1'b0;
        #1;
        check("ar_expired", int'(expired), 0);
        check("ar_state", int'(dut.state_q), int'(IDLE));
        #5 reset_global = 1'b1;
        for (int i = 0; i < 5; i++) run(1'b0, 0, 1'b1, 0, "ar_no_pulse");

        // Async reset while the pulse is high clears it before the next edge
        run(1'b1, 1, 1'b0, 0, "ar2_start");
        run(1'b0, 0, 1'b1, 1, "ar2_t1");
        #5 reset_global = 1'b0;
        #1;
        check("ar2_expired_cleared", int'(expired), 0);
        #5 reset_global = 1'b1;
        run(1'b0, 0, 1'b1, 0, "ar2_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
